// File: rtl/ula_ctrl_fsm.sv
// Multicycle control FSM for the lab CPU's 8-bit ALU datapath.
// Owns the PC, sequences fetch/decode/exec/mem/writeback with ack timeouts.
module ula_ctrl_fsm #(
    parameter int PC_W = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [7:0]      imem_data,
    input  logic            imem_ack,
    output logic [3:0]      alu_ctl,
    input  logic            alu_zero,
    output logic [1:0]      ra_sel,
    output logic [1:0]      rb_sel,
    output logic            rf_we,
    output logic [1:0]      rf_wsel,
    output logic            wb_src,
    output logic            dmem_rd,
    output logic            dmem_wr,
    input  logic            dmem_ack,
    output logic            busy,
    output logic            fault,
    output logic [2:0]      state
);

    localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

    localparam logic [2:0] OP_BNE = 3'd2;
    localparam logic [2:0] OP_LW  = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_BEQ = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_FOFF   = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } state_t;

    state_t          st, nxt;
    logic [PC_W-1:0] pc, pc_n;
    logic [7:0]      ir, ir_n;
    logic [7:0]      off, off_n;
    logic [CW-1:0]   wcnt, wcnt_n;

    logic            irq, drq, dwq;
    logic            acked;
    logic [3:0]      alu;
    logic            we, wbs;

    logic [2:0] op;
    logic       is_br;
    logic       ir_unused;

    assign op        = ir[7:5];
    assign is_br     = (op == OP_BNE) || (op == OP_BEQ);
    assign ir_unused = ir[0];

    // State and datapath-control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= S_FETCH;
            pc   <= RESET_PC;
            ir   <= '0;
            off  <= '0;
            wcnt <= '0;
        end else begin
            st   <= nxt;
            pc   <= pc_n;
            ir   <= ir_n;
            off  <= off_n;
            wcnt <= wcnt_n;
        end
    end

    // Next-state, strobes and wait-counter/timeout logic
    always_comb begin
        nxt    = st;
        pc_n   = pc;
        ir_n   = ir;
        off_n  = off;
        wcnt_n = '0;
        irq    = 1'b0;
        drq    = 1'b0;
        dwq    = 1'b0;
        acked  = 1'b0;
        alu    = 4'd0;
        we     = 1'b0;
        wbs    = 1'b0;
        unique case (st)
            S_FETCH: begin
                // a nonzero wait count means the read is already in flight
                irq = run || (wcnt != '0);
                if (irq && imem_ack) begin
                    acked = 1'b1;
                    ir_n  = imem_data;
                    pc_n  = pc + PC_W'(1);
                    nxt   = S_DECODE;
                end
            end
            S_DECODE: begin
                nxt = is_br ? S_FOFF : S_EXEC;
            end
            S_FOFF: begin
                irq = 1'b1;
                if (imem_ack) begin
                    acked = 1'b1;
                    off_n = imem_data;
                    pc_n  = pc + PC_W'(1);
                    nxt   = S_EXEC;
                end
            end
            S_EXEC: begin
                alu = {1'b0, op} + 4'd1;
                if (is_br) begin
                    if (alu_zero)
                        pc_n = pc + PC_W'($signed(off));
                    nxt = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    nxt = S_MEM;
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                alu = {1'b0, op} + 4'd1;
                drq = (op == OP_LW);
                dwq = (op == OP_SW);
                if (dmem_ack) begin
                    acked = 1'b1;
                    nxt   = (op == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                alu = {1'b0, op} + 4'd1;
                we  = 1'b1;
                wbs = (op == OP_LW);
                nxt = S_FETCH;
            end
            S_FAULT: begin
                nxt = S_FAULT;
            end
            default: begin
                nxt = S_FETCH;
            end
        endcase
        if ((irq || drq || dwq) && !acked) begin
            if (wcnt == WMAX)
                nxt = S_FAULT;
            else
                wcnt_n = wcnt + CW'(1);
        end
    end

    assign imem_addr = pc;
    assign imem_rd   = irq && !rst;
    assign dmem_rd   = drq && !rst;
    assign dmem_wr   = dwq && !rst;
    assign rf_we     = we && !rst;
    assign wb_src    = wbs && !rst;
    assign alu_ctl   = rst ? 4'd0 : alu;
    assign ra_sel    = ir[4:3];
    assign rb_sel    = ir[2:1];
    assign rf_wsel   = ir[4:3];
    assign busy      = !rst && !(st == S_FETCH && !irq);
    assign fault     = !rst && (st == S_FAULT);
    assign state     = st;

endmodule
